// File: rtl/axis_y_transpose_pkg.sv
// Shared sizing for the array output transpose buffer.
// Default array geometry, counter widths and bank index type.
package axis_y_transpose_pkg;

    localparam int Y_R  = 2;
    localparam int Y_C  = 2;
    localparam int Y_WY = 10;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int Y_CW = cnt_w(Y_C);
    localparam int Y_RW = cnt_w(Y_R);

    typedef logic bank_idx_t;

endpackage

// File: rtl/axis_y_transpose_y_bank.sv
// One R x C tile register bank: column write port, row read port.
// A zero-filling write also clears every column below the written one.
module y_bank
    import axis_y_transpose_pkg::*;
#(
    parameter int R  = Y_R,
    parameter int C  = Y_C,
    parameter int WY = Y_WY,
    parameter int CW = cnt_w(C),
    parameter int RW = cnt_w(R)
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic                   zfill,
    input  logic [CW-1:0]          wcol,
    input  logic [R-1:0][WY-1:0]   wdata,
    input  logic [RW-1:0]          rrow,
    output logic [C-1:0][WY-1:0]   rdata
);

    logic [R-1:0][C-1:0][WY-1:0] mem_q;
    logic [R-1:0][C-1:0][WY-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            for (int r = 0; r < R; r++) begin
                for (int c = 0; c < C; c++) begin
                    if (c == int'(wcol)) begin
                        mem_d[r][c] = wdata[r];
                    end else if (zfill && (c < int'(wcol))) begin
                        mem_d[r][c] = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        rdata = mem_q[rrow];
    end

endmodule

// File: rtl/axis_y_transpose.sv
// Ping-pong transpose buffer: array columns in (last column first),
// tile rows out in order 0..R-1, one AXI-stream beat per row.
module axis_y_transpose
    import axis_y_transpose_pkg::*;
#(
    parameter int R  = Y_R,
    parameter int C  = Y_C,
    parameter int WY = Y_WY
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_last,
    input  logic [R-1:0][WY-1:0]  s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [C-1:0][WY-1:0]  m_data,
    output logic                  err_last
);

    localparam int CW = (C == Y_C) ? Y_CW : cnt_w(C);
    localparam int RW = (R == Y_R) ? Y_RW : cnt_w(R);
    localparam logic [CW-1:0] WC_MAX = CW'(C - 1);
    localparam logic [RW-1:0] RR_MAX = RW'(R - 1);

    bank_idx_t         wb_q, wb_d;
    bank_idx_t         rb_q, rb_d;
    logic [CW-1:0]     wc_q, wc_d;
    logic [RW-1:0]     rr_q, rr_d;
    logic [1:0]        full_q, full_d;
    logic              err_q, err_d;

    logic              s_hs, m_hs, col_end, close;
    logic [1:0]        we;
    logic [CW-1:0]     wcol;
    logic [1:0][C-1:0][WY-1:0] rd;

    assign s_ready  = !full_q[wb_q];
    assign m_valid  = full_q[rb_q];
    assign m_last   = (rr_q == RR_MAX);
    assign m_data   = rd[rb_q];
    assign err_last = err_q;

    assign s_hs    = s_valid && s_ready;
    assign m_hs    = m_valid && m_ready;
    assign col_end = (wc_q == WC_MAX);
    assign close   = s_hs && (col_end || s_last);
    assign wcol    = WC_MAX - wc_q;

    // Write and read banks differ whenever both sides act, so the
    // set and clear of full flags never collide.
    always_comb begin
        wb_d   = wb_q;
        rb_d   = rb_q;
        wc_d   = wc_q;
        rr_d   = rr_q;
        full_d = full_q;
        we     = '0;
        err_d  = s_hs && (s_last != col_end);
        if (s_hs) begin
            we[wb_q] = 1'b1;
            wc_d     = wc_q + 1'b1;
        end
        if (close) begin
            full_d[wb_q] = 1'b1;
            wb_d         = ~wb_q;
            wc_d         = '0;
        end
        if (m_hs) begin
            if (rr_q == RR_MAX) begin
                full_d[rb_q] = 1'b0;
                rb_d         = ~rb_q;
                rr_d         = '0;
            end else begin
                rr_d = rr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q   <= 1'b0;
            rb_q   <= 1'b0;
            wc_q   <= '0;
            rr_q   <= '0;
            full_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wb_q   <= wb_d;
            rb_q   <= rb_d;
            wc_q   <= wc_d;
            rr_q   <= rr_d;
            full_q <= full_d;
            err_q  <= err_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        y_bank #(
            .R  (R),
            .C  (C),
            .WY (WY),
            .CW (CW),
            .RW (RW)
        ) u_bank (
            .clk   (clk),
            .we    (we[gi]),
            .zfill (s_last),
            .wcol  (wcol),
            .wdata (s_data),
            .rrow  (rr_q),
            .rdata (rd[gi])
        );
    end

endmodule
